// File: rtl/llr_frame_loader.sv
// llr_frame_loader
//
// Double-buffered serial-to-parallel loader for one FPTD frame of channel
// LLRs plus the reference decoded bits. LANES serial lanes fill a shadow
// buffer. A full shadow buffer is then copied into the active output
// registers, and Start is pulsed. While the decoder works on the active
// frame, the next frame can already be shifted in.
//
// Ports
//   Clock       system clock, rising edge
//   Reset       asynchronous, active-high reset
//   Go          enables the start of a new frame load
//   In          one serial bit per lane
//   InValid     qualifies In
//   Done        one-cycle pulse from the decoder: the active frame is consumed
//   LoadReq     shadow buffer is accepting bits (registered)
//   Start       one-cycle pulse: a new active frame is valid
//   but1, bua2, bua3, blt1, bla2   LLR fields, element i at bits [N*i +: N]
//   b1_ideal    reference decoded bits
//   FrameCount  number of completed transfers, wraps modulo 2^16
//   Overrun     sticky: InValid was seen while LoadReq was low
//   DbgState    FSM state (0 IDLE, 1 SHIFT, 2 FULL)
//   DbgCnt      shadow bit counter
//
// Handshakes
//   Input: InValid is the valid and LoadReq is the ready. A lane bit is
//   consumed on a rising edge only when InValid and LoadReq are both high.
//   If InValid is high while LoadReq is low, the bit is dropped and Overrun
//   is set.
//   Output: Start is a single-cycle notification with no back-pressure.
//   The frame stays owned by the decoder until it returns a one-cycle Done.
module llr_frame_loader #(
  parameter int FL    = 104,
  parameter int N     = 4,
  parameter int LANES = 7,
  parameter int SEG   = 200
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Go,
  input  logic [LANES-1:0]         In,
  input  logic                     InValid,
  input  logic                     Done,
  output logic                     LoadReq,
  output logic                     Start,
  output logic [3*N-1:0]           but1,
  output logic [(FL+3)*N-1:0]      bua2,
  output logic [FL*N-1:0]          bua3,
  output logic [3*N-1:0]           blt1,
  output logic [(FL+3)*N-1:0]      bla2,
  output logic [FL-1:0]            b1_ideal,
  output logic [15:0]              FrameCount,
  output logic                     Overrun,
  output logic [1:0]               DbgState,
  output logic [$clog2(SEG)-1:0]   DbgCnt
);

  localparam int CW     = $clog2(SEG);
  localparam int B_BUT1 = 0;
  localparam int B_BUA2 = B_BUT1 + 3 * N;
  localparam int B_BUA3 = B_BUA2 + (FL + 3) * N;
  localparam int B_BLT1 = B_BUA3 + FL * N;
  localparam int B_BLA2 = B_BLT1 + 3 * N;
  localparam int B_B1   = B_BLA2 + (FL + 3) * N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  // Each lane sends its segment from position SEG-1 down to position 0 and
  // shifts toward higher indices. After SEG shifts, shadow[l][p] therefore
  // holds stream bit l*SEG+p. Because lane 0 sits in the low bits of the
  // packed array, the flat view equals the stream with bit k at index k.
  logic [LANES-1:0][SEG-1:0] shadow;
  logic [LANES*SEG-1:0]      stream;
  logic [CW-1:0]             cnt;
  logic                      act_busy;

  logic shift_en;
  logic cnt_clr;
  logic xfer;
  logic cnt_last;

  assign stream   = shadow;
  assign cnt_last = (cnt == CW'(SEG - 1));
  assign DbgState = state;
  assign DbgCnt   = cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (Go) begin
          state_next = SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        // Go is ignored here on purpose: a load that has started always
        // runs to completion.
        if (InValid) begin
          shift_en = 1'b1;
          if (cnt_last) begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        // A Done in this cycle frees the active buffer at the same edge
        // that refills it, so the decoder loses no cycle between frames.
        if (!act_busy || Done) begin
          xfer       = 1'b1;
          cnt_clr    = 1'b1;
          state_next = Go ? SHIFT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shadow     <= '0;
      cnt        <= '0;
      LoadReq    <= 1'b0;
      Start      <= 1'b0;
      act_busy   <= 1'b0;
      FrameCount <= '0;
      Overrun    <= 1'b0;
      but1       <= '0;
      bua2       <= '0;
      bua3       <= '0;
      blt1       <= '0;
      bla2       <= '0;
      b1_ideal   <= '0;
    end else begin
      // LoadReq is computed from the next state, so it is high exactly
      // while the FSM is in SHIFT and is still a clean register output.
      LoadReq <= (state_next == SHIFT);
      Start   <= xfer;

      if (InValid && (state != SHIFT)) begin
        Overrun <= 1'b1;
      end

      if (cnt_clr) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt_last ? '0 : cnt + CW'(1);
      end

      if (shift_en) begin
        for (int l = 0; l < LANES; l++) begin
          shadow[l] <= {shadow[l][SEG-2:0], In[l]};
        end
      end

      if (xfer) begin
        but1       <= stream[B_BUT1 +: 3 * N];
        bua2       <= stream[B_BUA2 +: (FL + 3) * N];
        bua3       <= stream[B_BUA3 +: FL * N];
        blt1       <= stream[B_BLT1 +: 3 * N];
        bla2       <= stream[B_BLA2 +: (FL + 3) * N];
        b1_ideal   <= stream[B_B1 +: FL];
        act_busy   <= 1'b1;
        FrameCount <= FrameCount + 16'd1;
      end else if (Done) begin
        act_busy <= 1'b0;
      end
    end
  end

endmodule
